// File: rtl/graph_mem_arbiter_pkg.sv
// Shared types and default sizing for the graph memory subsystem.
// Any block sitting on a graph_memory port imports this package.
package graph_pkg;

    localparam int NUM_REQ_DEFAULT         = 4;
    localparam int ADDR_WIDTH_DEFAULT      = 32;
    localparam int DATA_WIDTH_DEFAULT      = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 8;

    typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;
    typedef logic [ADDR_WIDTH_DEFAULT-1:0]      mem_addr_t;

endpackage

// File: rtl/graph_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of graph_mem_arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface graph_mem_arbiter_if
    import graph_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEFAULT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) ();

    // Handshake: a request transfers on a cycle where req_valid_in[i] and
    // req_ready_out[i] are both high; the requester keeps valid and address
    // stable until then. Responses (resp_valid_out, mem_valid_in) are
    // strobes with no backpressure and must be sunk in the cycle they appear.
    logic [NUM_REQ-1:0]                  req_valid_in;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_in;
    logic [NUM_REQ-1:0]                  req_ready_out;
    logic [NUM_REQ-1:0]                  resp_valid_out;
    logic [DATA_WIDTH-1:0]               resp_data_out;
    logic [ADDR_WIDTH-1:0]               mem_req_out;
    logic                                mem_valid_out;
    logic [DATA_WIDTH-1:0]               mem_data_in;
    logic                                mem_valid_in;
    logic [$clog2(MAX_OUTSTANDING):0]    outstanding_out;
    logic                                err_out;

    modport master (
        output req_valid_in, req_addr_in, mem_data_in, mem_valid_in,
        input  req_ready_out, resp_valid_out, resp_data_out,
               mem_req_out, mem_valid_out, outstanding_out, err_out
    );

    modport slave (
        input  req_valid_in, req_addr_in, mem_data_in, mem_valid_in,
        output req_ready_out, resp_valid_out, resp_data_out,
               mem_req_out, mem_valid_out, outstanding_out, err_out
    );

endinterface

// File: rtl/graph_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping around, reported as one-hot grant plus binary index.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any_grant && req[j]) begin
                any_grant = 1'b1;
                grant_idx = IW'(j);
                grant[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Shares one graph_memory read port among NUM_REQ requesters and routes
// in-order read responses back to their issuers through an id FIFO.
module graph_mem_arbiter
    import graph_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEFAULT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input logic             clk_in,
    input logic             rst_in,
    graph_mem_arbiter_if.slave bus
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;

    logic [IDW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_idx;
    logic                  any_grant;

    logic [IDW-1:0]        id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [ADDR_WIDTH-1:0] mem_req_q;
    logic                  mem_valid_q;
    logic [NUM_REQ-1:0]    resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  err_q;

    logic                  not_full;
    logic                  push;
    logic                  pop;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (bus.req_valid_in),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Ready looks only at the registered count, so a same-cycle pop on a
    // full FIFO does not open a slot until the next cycle.
    assign not_full = (count != CW'(MAX_OUTSTANDING));
    assign push     = any_grant && not_full;
    assign pop      = bus.mem_valid_in && (count != '0);

    assign bus.req_ready_out   = not_full ? grant : '0;
    assign bus.mem_req_out     = mem_req_q;
    assign bus.mem_valid_out   = mem_valid_q;
    assign bus.resp_valid_out  = resp_valid_q;
    assign bus.resp_data_out   = resp_data_q;
    assign bus.outstanding_out = count;
    assign bus.err_out         = err_q;

    always_ff @(posedge clk_in) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mem_req_q    <= '0;
            mem_valid_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            mem_valid_q <= push;
            if (push) begin
                mem_req_q <= bus.req_addr_in[grant_idx];
                rr_ptr    <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                wr_ptr    <= wr_ptr + PW'(1);
            end

            resp_valid_q <= '0;
            if (pop) begin
                resp_valid_q <= NUM_REQ'(1) << id_mem[rd_ptr];
                resp_data_q  <= bus.mem_data_in;
                rd_ptr       <= rd_ptr + PW'(1);
            end

            // A response with nothing in flight has no owner: drop it, flag it.
            if (bus.mem_valid_in && (count == '0)) begin
                err_q <= 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Bench for graph_mem_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model and a response scoreboard.
module tb_graph_mem_arbiter;
    import graph_pkg::*;

    localparam int NR = NUM_REQ_DEFAULT;
    localparam int AW = ADDR_WIDTH_DEFAULT;
    localparam int DW = DATA_WIDTH_DEFAULT;
    localparam int MO = MAX_OUTSTANDING_DEFAULT;
    localparam int W  = NR + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    graph_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

    graph_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp_q [$];       // expected {one-hot owner, data}
    mem_addr_t   mem_q [$];        // reads seen at the memory, in issue order
    req_id_t     m_fifo [$];       // model: owners of reads in flight
    int          m_ptr;
    logic        m_err;
    logic        exp_mv;
    mem_addr_t   exp_ma;
    logic [NR-1:0] pending;
    mem_addr_t   ra [NR];
    int          gcnt [NR];
    bit          count_grants = 1'b0;
    logic [W-1:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input mem_addr_t a);
        return DW'((a ^ 32'hDEAD_0000) + 32'h0001_3579);
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus.resp_valid_out != '0) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'({bus.resp_valid_out, bus.resp_data_out}), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp", 64'({bus.resp_valid_out, bus.resp_data_out}), 64'(mon_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.req_valid_in = '0;
        bus.req_addr_in  = '0;
        bus.mem_valid_in = 1'b0;
        bus.mem_data_in  = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_valid",   64'(bus.mem_valid_out),   64'd0);
        chk("rst_mem_req",     64'(bus.mem_req_out),     64'd0);
        chk("rst_resp_valid",  64'(bus.resp_valid_out),  64'd0);
        chk("rst_resp_data",   64'(bus.resp_data_out),   64'd0);
        chk("rst_outstanding", 64'(bus.outstanding_out), 64'd0);
        chk("rst_err",         64'(bus.err_out),         64'd0);
        m_fifo.delete();
        mem_q.delete();
        m_ptr   = 0;
        m_err   = 1'b0;
        exp_mv  = 1'b0;
        exp_ma  = '0;
        pending = '0;
    endtask

    // One clock of stimulus: check last edge's registered outputs, apply new
    // inputs, check the combinational grant, then advance the model.
    task automatic cycle(input logic [NR-1:0] v, input bit mv);
        logic [NR-1:0] rdy_exp;
        logic [DW-1:0] md;
        int            g;
        int            j;
        @(negedge clk);
        chk("mem_valid",   64'(bus.mem_valid_out),   64'(exp_mv));
        chk("mem_req",     64'(bus.mem_req_out),     64'(exp_ma));
        chk("outstanding", 64'(bus.outstanding_out), 64'(m_fifo.size()));
        chk("err",         64'(bus.err_out),         64'(m_err));
        if (bus.mem_valid_out) mem_q.push_back(bus.mem_req_out);

        for (int i = 0; i < NR; i++) begin
            if (v[i] && !pending[i]) ra[i] = mem_addr_t'($urandom);
            bus.req_addr_in[i] = ra[i];
        end
        bus.req_valid_in = v;
        if (mv && mem_q.size() > 0) md = mem_word(mem_q.pop_front());
        else                        md = DW'($urandom);
        bus.mem_valid_in = mv;
        bus.mem_data_in  = md;

        g = -1;
        for (int k = 0; k < NR; k++) begin
            j = (m_ptr + k) % NR;
            if (g < 0 && v[j]) g = j;
        end
        rdy_exp = (g >= 0 && m_fifo.size() < MO) ? (NR'(1) << g) : '0;

        #1;
        chk("ready", 64'(bus.req_ready_out), 64'(rdy_exp));
        if (count_grants) for (int i = 0; i < NR; i++) gcnt[i] += int'(bus.req_ready_out[i]);

        if (mv && m_fifo.size() == 0) m_err = 1'b1;
        if (mv && m_fifo.size() > 0) exp_q.push_back({NR'(1) << m_fifo.pop_front(), md});
        if (rdy_exp != '0) begin
            m_fifo.push_back(req_id_t'(g));
            m_ptr  = (g + 1) % NR;
            exp_mv = 1'b1;
            exp_ma = ra[g];
        end else begin
            exp_mv = 1'b0;
        end
        pending = v & ~rdy_exp;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && m_fifo.size() > 0; n++) cycle('0, 1'b1);
        chk("drain_done", 64'(m_fifo.size()), 64'd0);
        repeat (2) cycle('0, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.req_valid_in = '0;
        bus.req_addr_in  = '0;
        bus.mem_valid_in = 1'b0;
        bus.mem_data_in  = '0;
        do_reset();

        // single request from requester 2, memory answers 3 cycles later
        ra[2] = 32'h40; pending[2] = 1'b1;
        cycle(4'b0100, 1'b0);
        repeat (3) cycle('0, 1'b0);
        cycle('0, 1'b1);
        repeat (2) cycle('0, 1'b0);

        // fairness from a fresh pointer: 8 grants, 2 each
        do_reset();
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        count_grants = 1'b1;
        repeat (8) cycle('1, 1'b0);
        count_grants = 1'b0;
        for (int i = 0; i < NR; i++) chk($sformatf("fair_%0d", i), 64'(gcnt[i]), 64'd2);

        // full: no ready while stalled, one pop frees exactly one accept
        repeat (2) cycle('1, 1'b0);
        cycle('1, 1'b1);
        cycle('1, 1'b0);
        cycle('1, 1'b0);
        drain();

        // out-of-turn routing 3,1,1,0 with overlapping push/pop
        cycle(4'b1000, 1'b0);
        cycle(4'b0010, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b0001, 1'b1);
        cycle('0, 1'b1);
        drain();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            cycle(pending | NR'($urandom), (m_fifo.size() > 0) && ($urandom_range(0, 2) != 0));
        end
        drain();

        // spurious response sets a sticky error
        cycle('0, 1'b1);
        repeat (3) cycle('0, 1'b0);

        // reset with reads in flight, then a late response and a fresh grant
        cycle(4'b0001, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0100, 1'b0);
        do_reset();
        cycle('0, 1'b1);
        cycle('1, 1'b0);
        cycle('0, 1'b0);
        drain();

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
